wiscsc15_mem_arb: RTL
=====================

Name: wiscsc15_mem_arb

Overview:
- Shares one single-port, fixed-latency unified memory between the WISC-SC15 instruction-fetch port and the data-memory port (lw/sw/call/ret traffic).
- Arbitrates between the two ports, sequences each access through issue, wait and completion, and returns read data with a one-cycle done pulse.
- Data accesses have priority. A starvation guard guarantees fetch progress.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..7)
STARVE_MAX, 3, consecutive data grants allowed while fetch is waiting (legal range 1..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held high with if_addr stable until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word; valid while if_done=1, holds afterward
if_done  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request; held high with dm_we/dm_addr/dm_wdata stable until dm_done
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data; valid while dm_done=1, holds afterward
dm_done  out  1  one-cycle data completion pulse
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle
busy  out  1  1 in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- All outputs are registered. On reset every output is 0 (including if_rdata, dm_rdata, mem_addr, mem_wdata), the state is IDLE and the starvation counter is 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample the requests.
  - Neither request: stay in IDLE.
  - Only one request: grant that port.
  - Both requests: grant data if starve_cnt < STARVE_MAX, otherwise grant fetch.
  - On a grant, latch the owner, address, we and wdata, then go to ISSUE. If_req has no we; fetch is always a read.
- ISSUE: one cycle.
  - mem_en=1; mem_addr and mem_wdata from the latched values; mem_we = latched we for data, 0 for fetch.
  - Load the wait counter with MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle.
  - In the cycle the counter is 1 (cycle ISSUE+MEM_LAT), capture mem_rdata into the owner's rdata register (reads only; writes leave both rdata registers unchanged) and go to DONE.
- DONE: one cycle.
  - Owner's done=1; the other done=0. The next state is always IDLE.
  - Requests are ignored in DONE. A requester wanting back-to-back accesses keeps req high and is re-sampled in the following IDLE cycle.
- mem_en, mem_we and both done signals are 0 outside ISSUE and DONE respectively. mem_addr and mem_wdata hold their last values.
- Latency: a request first seen in IDLE at cycle 0 gives mem_en in cycle 1 and done in cycle MEM_LAT+2. The minimum spacing between accesses is MEM_LAT+3 cycles.
- Starvation counter (3 bits, saturating at STARVE_MAX), updated only at the IDLE grant:
  - Data granted while if_req=1: increment.
  - Fetch granted, or if_req=0 at the grant: clear to 0.
- A request dropped before done is a protocol violation; the access still completes and the done pulse is still issued.
- Reset mid-operation: the in-flight access is abandoned, no done pulse is issued, and a later mem_rdata value is ignored.
- dm_rdata and if_rdata update only on a read completion for their own port.

Test Plan:
- Reset, then dm_req=1, dm_we=0, dm_addr=0x0040, with memory returning 0xBEEF -> mem_en in cycle 1 with mem_addr=0x0040 and mem_we=0; dm_done=1 in cycle 4 with dm_rdata=0xBEEF (MEM_LAT=2); if_done stays 0.
- Fetch if_addr=0x0100 returning 0x1234 and held -> if_done in cycle 4; second mem_en in cycle 6 (back-to-back spacing of 5); if_rdata=0x1234 held between the done pulses.
- Data write dm_addr=0x0010, dm_wdata=0xA5A5 -> mem_en=1 and mem_we=1 with the same addr/wdata in cycle 1; dm_done in cycle 4; dm_rdata unchanged.
- if_req and dm_req both held continuously, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I; the counter never exceeds 3.
- rst asserted in the WAIT cycle of a data read -> next cycle all outputs are 0 and the state is IDLE; no dm_done pulse; dm_rdata=0.
- MEM_LAT=1 build: a single read -> done in cycle 3; mem_rdata sampled in cycle 2 only; a value changed in cycle 3 has no effect.

Source files
------------

// File: rtl/wiscsc15_mem_arb.sv
// Arbiter sharing one fixed-latency single-port memory between the WISC-SC15
// instruction-fetch port and the data-memory port; data has priority, fetch is starvation-guarded.
module wiscsc15_mem_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     state;
    logic       owner_dm;
    logic       lat_we;
    logic [2:0] wait_cnt;
    logic [2:0] starve_cnt;
    logic       grant_dm;

    // Data wins a collision until fetch has been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_dm = dm_req && (!if_req || (starve_cnt < STARVE_LIM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            lat_we     <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            if_done    <= 1'b0;
            dm_rdata   <= '0;
            dm_done    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req || if_req) begin
                        // Output registers double as the latched request, so mem_en lands in ISSUE.
                        owner_dm <= grant_dm;
                        lat_we   <= grant_dm & dm_we;
                        mem_en   <= 1'b1;
                        mem_we   <= grant_dm & dm_we;
                        mem_addr <= grant_dm ? dm_addr : if_addr;
                        if (grant_dm)
                            mem_wdata <= dm_wdata;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                        if (grant_dm && if_req)
                            starve_cnt <= (starve_cnt < STARVE_LIM) ? starve_cnt + 3'd1 : starve_cnt;
                        else
                            starve_cnt <= '0;
                    end
                end
                ISSUE: begin
                    wait_cnt <= LAT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        if (!lat_we) begin
                            if (owner_dm)
                                dm_rdata <= mem_rdata;
                            else
                                if_rdata <= mem_rdata;
                        end
                        if (owner_dm)
                            dm_done <= 1'b1;
                        else
                            if_done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
